theta_update_arbiter: RTL and testbench
=======================================

# theta_update_arbiter

Shares the single theta accumulator between two producers of angle increments: wheel-encoder odometry (ENC) and IMU gyro correction (IMU). Accepts one request at a time through a req/ack handshake and grants it round-robin. For each grant it latches the requester's delta, pulses the accumulator's `start`, waits for `done` under a watchdog, then acknowledges. The block sits between the odometry/IMU front ends and the accumulator's `start`/`delta_theta`/`done` ports.

## Interface
- `DATA_W`, 64: width of signed delta, in microradians.
- `TIMEOUT_CYCLES`, 16: number of WAIT cycles without `acc_done` before the watchdog aborts the grant; legal range 2..255.
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-low reset.
- `req_enc` input 1: ENC request; held until `ack_enc`.
- `delta_enc` input DATA_W signed: ENC increment; stable while `req_enc` is high.
- `ack_enc` output 1: one-cycle acknowledge to ENC.
- `req_imu`, `delta_imu`, `ack_imu`: the same three signals for IMU.
- `ack_err` output 1: qualifies an `ack_*` pulse; high means the grant timed out.
- `acc_start` output 1: one-cycle start pulse to the accumulator.
- `acc_delta` output DATA_W signed: registered delta driven to the accumulator.
- `acc_done` input 1: accumulator completion; sampled only in WAIT.
- `busy` output 1: high in every state except IDLE.
- `grant_id` output 1: 0 = ENC, 1 = IMU; valid while `busy`.
- `timeout_err` output 1: sticky; set on any watchdog abort; cleared only by reset.
- `update_count` output 16: number of successful (non-timeout) grants; wraps.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. The state register is the only source of `acc_start`, `busy`, and the `ack_*` pulses.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester not granted most recently. The pointer is ENC-first after reset.
  - On a grant: latch the delta into `acc_delta`, set `grant_id`, clear the watchdog, go to ISSUE.
- **ISSUE**: `acc_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Watchdog increments each cycle.
  - `acc_done`=1: go to ACK with error = 0.
  - Watchdog reaches `TIMEOUT_CYCLES`: go to ACK with error = 1 and set `timeout_err`.
  - `acc_done` in the same cycle the watchdog expires: done wins, no error.
- **ACK**
  - Pulse `ack_enc` or `ack_imu` (selected by `grant_id`) with `ack_err` = the latched error.
  - Update the round-robin pointer to the granted requester.
  - If no error, increment `update_count`.
  - Return to IDLE.
- Requester rules:
  - Drop `req` in the cycle after `ack`.
  - A `req` still high in IDLE after `ack` is treated as a new request.
  - A request arriving while `busy` waits; it is never lost.
  - The delta is captured only in IDLE, so changes during a grant have no effect.
- Arithmetic:
  - `acc_delta` is passed unmodified; no saturation or normalization here (normalization is the accumulator's job).
  - `update_count` wraps 0xFFFF → 0x0000.
- Reset values (while `reset`=0, applied on the clock edge): state IDLE; `acc_start`, `ack_*`, `ack_err`, `busy`, `grant_id`, `timeout_err` = 0; `acc_delta` = 0; `update_count` = 0; pointer = ENC-first.
- Reset mid-grant: return to IDLE and abandon the grant with no `ack`. The accumulator shares `reset`, so it is cleared at the same time.

## Timing
- `req` sampled high in IDLE at edge k:
  - `acc_start` high during cycle k+1.
  - WAIT is entered from cycle k+2.
- `acc_done` sampled at edge m in WAIT: `ack_*` high during cycle m+1, IDLE at m+2.
- Back-to-back: a pending request is sampled at edge m+2, so the minimum period is 4 cycles plus the accumulator latency.
- Timeout path: `ack_*` with `ack_err`=1 arrives `TIMEOUT_CYCLES`+3 cycles after the grant edge.
- `acc_done` outside WAIT is ignored.

## Structure
- Shared package `theta_sched_pkg` holds:
  - state enum (IDLE/ISSUE/WAIT/ACK);
  - grant constants `GRANT_ENC`=0 and `GRANT_IMU`=1;
  - default `DATA_W` and `TIMEOUT_CYCLES`.
- One sub-module, `theta_sched_watchdog`: an 8-bit counter with `clear`/`enable` inputs and an `expired` output (count == `TIMEOUT_CYCLES`).
- Arbiter pointer, FSM, and output registers live in the top module.
- The design pairs with the existing accumulator top-level through `acc_start`→`start`, `acc_delta`→`delta_theta`, and `done`→`acc_done`.

## Test plan
- **Single ENC request**: `req_enc`=1, `delta_enc`=+1500; accumulator `done` 3 cycles after start. Expect `acc_start` at k+1, `acc_delta`=1500, `ack_enc` with `ack_err`=0, `update_count`=1.
- **Simultaneous requests after reset**: `req_enc` and `req_imu` asserted together, deltas +100 and -250. Expect ENC granted first, IMU second; accumulated theta = -150; ack order ENC then IMU.
- **Fairness**: both requests held high for 6 grants. Expect `grant_id` alternating 0,1,0,1,0,1 with no starvation.
- **Timeout**: stub `acc_done` tied to 0, `TIMEOUT_CYCLES`=16. Expect `ack_imu` with `ack_err`=1 exactly 19 cycles after the grant edge, `timeout_err` sticky at 1, `update_count` unchanged.
- **Done meets watchdog expiry**: `acc_done` in the expiry cycle. Expect `ack_err`=0 and `update_count` incremented.
- **Reset mid-WAIT, plus counter wrap**: `reset`=0 during WAIT. Expect all outputs at reset values the next cycle and no `ack`. Separately, preload the count to 0xFFFF; one more successful grant gives `update_count`=0x0000.

Source files
------------

// File: rtl/theta_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// theta_sched_pkg: shared types and defaults for the theta update arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
package theta_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic GRANT_ENC = 1'b0;
  localparam logic GRANT_IMU = 1'b1;

  localparam int DEFAULT_DATA_W         = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/theta_update_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// theta_update_arbiter_if: requester, accumulator and status signals.
// Rev 1.0
// ----------------------------------------------------------------------------
interface theta_update_arbiter_if
  import theta_sched_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic                     req_enc;
  logic signed [DATA_W-1:0] delta_enc;
  logic                     ack_enc;
  logic                     req_imu;
  logic signed [DATA_W-1:0] delta_imu;
  logic                     ack_imu;
  logic                     ack_err;
  logic                     acc_start;
  logic signed [DATA_W-1:0] acc_delta;
  logic                     acc_done;
  logic                     busy;
  logic                     grant_id;
  logic                     timeout_err;
  logic [15:0]              update_count;

  // master is the arbiter itself; slave is the requester/accumulator side
  modport master (
    input  req_enc, delta_enc, req_imu, delta_imu, acc_done,
    output ack_enc, ack_imu, ack_err, acc_start, acc_delta,
           busy, grant_id, timeout_err, update_count
  );

  modport slave (
    output req_enc, delta_enc, req_imu, delta_imu, acc_done,
    input  ack_enc, ack_imu, ack_err, acc_start, acc_delta,
           busy, grant_id, timeout_err, update_count
  );
endinterface
`default_nettype wire

// File: rtl/theta_sched_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// theta_sched_watchdog: 8-bit grant watchdog, expired when count hits TIMEOUT_CYCLES.
// Rev 1.0
// ----------------------------------------------------------------------------
module theta_sched_watchdog
  import theta_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q;

  assign expired_o = (count_q == 8'(TIMEOUT_CYCLES));

  // Saturates at the limit so a long WAIT can never wrap back below it
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else if (clear_i) begin
      count_q <= 8'd0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/theta_update_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// theta_update_arbiter: round-robin ENC/IMU access to the theta accumulator.
// Rev 1.0
// ----------------------------------------------------------------------------
module theta_update_arbiter
  import theta_sched_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  theta_update_arbiter_if.master bus
);

  state_e                   state_q;
  logic                     acc_start_q;
  logic                     ack_enc_q;
  logic                     ack_imu_q;
  logic                     ack_err_q;
  logic                     busy_q;
  logic                     grant_id_q;
  logic                     timeout_err_q;
  logic                     rr_last_q;
  logic signed [DATA_W-1:0] acc_delta_q;
  logic [15:0]              update_count_q;
  logic [15:0]              update_count_d;
  logic                     grant_sel;
  logic                     wd_expired;

  theta_sched_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  // On contention the requester not served last wins
  always_comb begin
    grant_sel = GRANT_ENC;
    if (bus.req_enc && bus.req_imu) begin
      grant_sel = ~rr_last_q;
    end else if (bus.req_imu) begin
      grant_sel = GRANT_IMU;
    end
  end

  always_comb begin
    update_count_d = update_count_q;
    if (state_q == ST_ACK && !ack_err_q) begin
      update_count_d = update_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      acc_start_q    <= 1'b0;
      ack_enc_q      <= 1'b0;
      ack_imu_q      <= 1'b0;
      ack_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      grant_id_q     <= GRANT_ENC;
      timeout_err_q  <= 1'b0;
      rr_last_q      <= GRANT_IMU;  // makes ENC the first winner
      acc_delta_q    <= '0;
      update_count_q <= 16'd0;
    end else begin
      acc_start_q    <= 1'b0;
      ack_enc_q      <= 1'b0;
      ack_imu_q      <= 1'b0;
      ack_err_q      <= 1'b0;
      update_count_q <= update_count_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_enc || bus.req_imu) begin
            state_q     <= ST_ISSUE;
            grant_id_q  <= grant_sel;
            acc_delta_q <= (grant_sel == GRANT_IMU) ? bus.delta_imu : bus.delta_enc;
            acc_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over a watchdog expiring in the same cycle
          if (bus.acc_done || wd_expired) begin
            state_q   <= ST_ACK;
            ack_err_q <= ~bus.acc_done;
            ack_enc_q <= (grant_id_q == GRANT_ENC);
            ack_imu_q <= (grant_id_q == GRANT_IMU);
            if (!bus.acc_done) begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          rr_last_q <= grant_id_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.acc_start    = acc_start_q;
  assign bus.acc_delta    = acc_delta_q;
  assign bus.ack_enc      = ack_enc_q;
  assign bus.ack_imu      = ack_imu_q;
  assign bus.ack_err      = ack_err_q;
  assign bus.busy         = busy_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.update_count = update_count_q;

endmodule
`default_nettype wire

// File: tb/tb_theta_update_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_theta_update_arbiter: directed + randomized bench with a transaction-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_theta_update_arbiter;
  import theta_sched_pkg::*;

  localparam int DW = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  theta_update_arbiter_if #(.DATA_W(DW)) bus ();

  theta_update_arbiter #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  longint      enc_q[$];
  longint      imu_q[$];
  int          lat_q[$];
  int          grant_log[$];
  logic        last_g   = 1'b1;
  logic [15:0] m_count  = 16'd0;
  logic        m_sticky = 1'b0;
  bit          inflight = 1'b0;
  logic        inf_g    = 1'b0;
  bit          inf_err  = 1'b0;
  int          inf_age  = 0;
  int          exp_age  = 0;
  int          dcnt     = -1;
  longint      acc_hold = 0;
  longint      theta    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint rand_delta();
    return longint'({$urandom(), $urandom()});
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return -1;
    return int'($urandom_range(1, 20));
  endfunction

  task automatic drive_reqs();
    if (!bus.req_enc && enc_q.size() > 0) begin
      bus.req_enc   = 1'b1;
      bus.delta_enc = enc_q[0];
    end
    if (!bus.req_imu && imu_q.size() > 0) begin
      bus.req_imu   = 1'b1;
      bus.delta_imu = imu_q[0];
    end
  endtask

  // One clock: accumulator stub, grant/ack checks against the model, requesters
  task automatic step();
    logic   eg;
    longint ed;
    int     lat;
    @(posedge clk);
    #1;
    if (!reset) return;
    bus.acc_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) begin
        bus.acc_done = 1'b1;
        theta += acc_hold;
        dcnt = -1;
      end
    end
    if (inflight) begin
      inf_age++;
      if (inf_age <= exp_age) check("busy_grant", bus.busy, 1);
      if (inf_age == exp_age) begin
        check("ack_enc", bus.ack_enc, inf_g == 1'b0);
        check("ack_imu", bus.ack_imu, inf_g == 1'b1);
        check("ack_err", bus.ack_err, inf_err);
        last_g = inf_g;
        if (inf_err) m_sticky = 1'b1;
        else m_count = m_count + 16'd1;
        if (inf_g) begin
          if (imu_q.size() > 0) void'(imu_q.pop_front());
          bus.req_imu = 1'b0;
        end else begin
          if (enc_q.size() > 0) void'(enc_q.pop_front());
          bus.req_enc = 1'b0;
        end
        inflight = 1'b0;
      end else begin
        check("no_ack", {bus.ack_enc, bus.ack_imu}, 2'b00);
      end
    end else begin
      check("no_ack", {bus.ack_enc, bus.ack_imu}, 2'b00);
    end
    if (bus.acc_start) begin
      check("start_idle", inflight, 0);
      check("start_req", bus.req_enc | bus.req_imu, 1);
      eg = (bus.req_enc && bus.req_imu) ? ~last_g : bus.req_imu;
      if (eg) ed = (imu_q.size() > 0) ? imu_q[0] : 64'sd0;
      else    ed = (enc_q.size() > 0) ? enc_q[0] : 64'sd0;
      check("grant_id", bus.grant_id, eg);
      check("acc_delta", bus.acc_delta, ed);
      grant_log.push_back(int'(eg));
      lat      = (lat_q.size() > 0) ? lat_q.pop_front() : 3;
      inflight = 1'b1;
      inf_g    = eg;
      inf_age  = 0;
      inf_err  = (lat < 0) || (lat > TO + 1);
      exp_age  = inf_err ? TO + 2 : lat + 1;
      dcnt     = lat;
      acc_hold = bus.acc_delta;
    end
    drive_reqs();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((enc_q.size() > 0 || imu_q.size() > 0 || inflight || bus.busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, n < budget, 1);
    step();
    check({tag, "_count"}, bus.update_count, m_count);
    check({tag, "_sticky"}, bus.timeout_err, m_sticky);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_start"}, bus.acc_start, 0);
    check({tag, "_ack"}, {bus.ack_enc, bus.ack_imu, bus.ack_err}, 3'b000);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_grant_id"}, bus.grant_id, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    check({tag, "_acc_delta"}, bus.acc_delta, 0);
    check({tag, "_count"}, bus.update_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_enc  = 1'b0;
    bus.req_imu  = 1'b0;
    bus.acc_done = 1'b0;
    step();
    step();
    reset = 1'b1;
    enc_q.delete();
    imu_q.delete();
    lat_q.delete();
    grant_log.delete();
    inflight = 1'b0;
    dcnt     = -1;
    last_g   = 1'b1;
    m_count  = 16'd0;
    m_sticky = 1'b0;
    theta    = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req_enc   = 1'b0;
    bus.req_imu   = 1'b0;
    bus.delta_enc = '0;
    bus.delta_imu = '0;
    bus.acc_done  = 1'b0;

    // Reset state
    reset = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    do_reset();

    // Single ENC request, done 3 cycles after start
    enc_q.push_back(64'sd1500);
    lat_q.push_back(3);
    drive_reqs();
    step();
    check("single_start_latency", bus.acc_start, 1);
    check("single_delta", bus.acc_delta, 64'sd1500);
    wait_idle("single", 200);
    check("single_count_one", bus.update_count, 16'd1);

    // Simultaneous requests right after reset: ENC then IMU, theta = -150
    do_reset();
    enc_q.push_back(64'sd100);
    imu_q.push_back(-64'sd250);
    lat_q.push_back(2);
    lat_q.push_back(4);
    drive_reqs();
    wait_idle("simul", 200);
    check("simul_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("simul_first", grant_log[0], 0);
      check("simul_second", grant_log[1], 1);
    end
    check("simul_theta", theta, -64'sd150);

    // Fairness: both held high for 6 grants
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      enc_q.push_back(rand_delta());
      imu_q.push_back(rand_delta());
      lat_q.push_back(int'($urandom_range(1, 6)));
      lat_q.push_back(int'($urandom_range(1, 6)));
    end
    drive_reqs();
    wait_idle("fair", 500);
    check("fair_grants", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size() && i < 6; i++) check("fair_alternate", grant_log[i], i % 2);

    // Timeout: IMU grant never completes
    imu_q.push_back(-64'sd777);
    lat_q.push_back(-1);
    drive_reqs();
    wait_idle("timeout", 200);
    check("timeout_sticky_set", bus.timeout_err, 1);

    // Done in the expiry cycle wins; one cycle later it is ignored
    enc_q.push_back(64'sd4242);
    lat_q.push_back(TO + 1);
    drive_reqs();
    wait_idle("expiry_done", 200);
    imu_q.push_back(64'sd17);
    lat_q.push_back(TO + 2);
    drive_reqs();
    wait_idle("expiry_late", 200);

    // Randomized arrivals while busy, mixed latencies and timeouts
    for (int i = 0, pushes = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0 && pushes < 24) begin
        enc_q.push_back(rand_delta());
        lat_q.push_back(rand_lat());
        pushes++;
      end
      if ($urandom_range(0, 3) == 0 && pushes < 24) begin
        imu_q.push_back(rand_delta());
        lat_q.push_back(rand_lat());
        pushes++;
      end
      drive_reqs();
      step();
    end
    wait_idle("random", 4000);

    // Reset mid-WAIT after an ENC grant completed, so the pointer favours IMU
    enc_q.push_back(64'sd700);
    lat_q.push_back(2);
    drive_reqs();
    wait_idle("pre_reset", 200);
    enc_q.push_back(64'sd900);
    lat_q.push_back(-1);
    drive_reqs();
    for (int i = 0; i < 20 && !(inflight && inf_age >= 4); i++) step();
    check("midwait_reached", inflight && inf_age >= 4, 1);
    reset = 1'b0;
    bus.req_enc = 1'b0;
    step();
    check_reset_outputs("midwait");
    do_reset();
    for (int i = 0; i < 6; i++) step();

    // Pointer is ENC-first again after reset
    enc_q.push_back(64'sd11);
    imu_q.push_back(64'sd22);
    lat_q.push_back(1);
    lat_q.push_back(1);
    drive_reqs();
    wait_idle("post_reset", 200);
    check("post_reset_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("post_reset_enc_first", grant_log[0], 0);

    // Counter wrap from 0xFFFF
    force dut.update_count_d = 16'hFFFF;
    step();
    release dut.update_count_d;
    m_count = 16'hFFFF;
    step();
    check("wrap_preload", bus.update_count, 16'hFFFF);
    enc_q.push_back(64'sd5);
    lat_q.push_back(2);
    drive_reqs();
    wait_idle("wrap", 200);
    check("wrap_zero", bus.update_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
